// File: rtl/refresh_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : refresh_ctrl_if
// Brief    : Request/grant and DRAM command signals of the refresh controller.
// Revision : 1.0
// ============================================================================
interface refresh_ctrl_if #(
    parameter int RANKS  = 1,
    parameter int DEBT_W = 4
);
    logic              refresh_force;
    logic              ref_gnt;
    logic              ref_req;
    logic              ref_busy;
    logic              ref_urgent;
    logic              ref_overflow;
    logic [DEBT_W-1:0] debt;
    logic [RANKS-1:0]  cs_n;
    logic              ras_n;
    logic              cas_n;
    logic              we_n;
    logic              a10;

    modport master (
        input  refresh_force, ref_gnt,
        output ref_req, ref_busy, ref_urgent, ref_overflow, debt,
               cs_n, ras_n, cas_n, we_n, a10
    );

    modport slave (
        output refresh_force, ref_gnt,
        input  ref_req, ref_busy, ref_urgent, ref_overflow, debt,
               cs_n, ras_n, cas_n, we_n, a10
    );
endinterface
`default_nettype wire

// File: rtl/refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : refresh_ctrl
// Brief    : DRAM auto-refresh controller: tREFI timer, postponed-refresh debt,
//            bus request/grant and per-rank PRECHARGE-ALL + AUTO-REFRESH.
// Revision : 1.0
// ============================================================================
module refresh_ctrl #(
    parameter int RANKS        = 1,
    parameter int T_REFI       = 7800,
    parameter int T_RP         = 15,
    parameter int T_RFC        = 103,
    parameter int MAX_POSTPONE = 8,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    refresh_ctrl_if.master bus
);
    localparam int c_DEBT_W = $clog2(MAX_POSTPONE + 1);
    localparam int c_RANK_W = (RANKS > 1) ? $clog2(RANKS) : 1;

    localparam logic [CNT_W-1:0]    c_REFI_RLD  = CNT_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0]    c_RP_RLD    = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0]    c_RFC_RLD   = CNT_W'(T_RFC - 2);
    localparam logic [c_RANK_W-1:0] c_LAST_RANK = c_RANK_W'(RANKS - 1);
    localparam logic [c_DEBT_W-1:0] c_MAX_DEBT  = c_DEBT_W'(MAX_POSTPONE);
    localparam logic [c_DEBT_W:0]   c_MAX_SUM   = (c_DEBT_W + 1)'(MAX_POSTPONE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_PREA = 3'd2,
        S_TRP  = 3'd3,
        S_REF  = 3'd4,
        S_RFC  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_refi_cnt;
    logic [CNT_W-1:0]    r_wait;
    logic [c_RANK_W-1:0] r_rank;
    logic [c_DEBT_W-1:0] r_debt;
    logic                r_overflow;
    logic                w_tick;
    logic                w_wait_done;
    logic                w_session_done;
    logic                w_rank_inc;
    logic [c_DEBT_W:0]   w_debt_sum;
    logic                w_sat;

    assign w_tick      = (r_refi_cnt == '0);
    assign w_wait_done = (r_wait == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refi_cnt <= c_REFI_RLD;
        end else if (w_tick) begin
            r_refi_cnt <= c_REFI_RLD;
        end else begin
            r_refi_cnt <= r_refi_cnt - 1'b1;
        end
    end

    // Reloaded on the single-cycle command states so the wait state that
    // follows lasts exactly (T - 1) cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else begin
            case (r_state)
                S_PREA:  r_wait <= c_RP_RLD;
                S_REF:   r_wait <= c_RFC_RLD;
                default: if (!w_wait_done) r_wait <= r_wait - 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_session_done = 1'b0;
        w_rank_inc     = 1'b0;
        case (r_state)
            S_IDLE: if (r_debt != '0) w_state_nxt = S_REQ;
            S_REQ:  if (bus.ref_gnt) w_state_nxt = S_PREA;
            S_PREA: w_state_nxt = S_TRP;
            S_TRP:  if (w_wait_done) w_state_nxt = S_REF;
            S_REF:  w_state_nxt = S_RFC;
            S_RFC: begin
                if (w_wait_done) begin
                    if (r_rank == c_LAST_RANK) begin
                        w_session_done = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_rank_inc  = 1'b1;
                        w_state_nxt = S_PREA;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rank <= '0;
        end else if (r_state == S_REQ && bus.ref_gnt) begin
            r_rank <= '0;
        end else if (w_rank_inc) begin
            r_rank <= r_rank + 1'b1;
        end
    end

    // Debt never underflows: a session only starts with debt > 0 and retires
    // exactly one unit when it completes.
    assign w_debt_sum = {1'b0, r_debt}
                      + {{c_DEBT_W{1'b0}}, w_tick}
                      + {{c_DEBT_W{1'b0}}, bus.refresh_force}
                      - {{c_DEBT_W{1'b0}}, w_session_done};
    assign w_sat      = (w_debt_sum > c_MAX_SUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_debt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_debt <= w_sat ? c_MAX_DEBT : w_debt_sum[c_DEBT_W-1:0];
            if (w_sat) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        bus.cs_n  = '1;
        bus.ras_n = 1'b1;
        bus.cas_n = 1'b1;
        bus.we_n  = 1'b1;
        bus.a10   = 1'b0;
        case (r_state)
            S_PREA: begin
                bus.cs_n[r_rank] = 1'b0;
                bus.ras_n        = 1'b0;
                bus.we_n         = 1'b0;
                bus.a10          = 1'b1;
            end
            S_REF: begin
                bus.cs_n[r_rank] = 1'b0;
                bus.ras_n        = 1'b0;
                bus.cas_n        = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.ref_req      = (r_state == S_REQ);
    assign bus.ref_busy     = (r_state == S_PREA) || (r_state == S_TRP) ||
                              (r_state == S_REF)  || (r_state == S_RFC);
    assign bus.ref_urgent   = (r_debt >= c_MAX_DEBT);
    assign bus.ref_overflow = r_overflow;
    assign bus.debt         = r_debt;
endmodule
`default_nettype wire
